sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_ctrl_pkg.sv | 6 +
 rtl/sram_fifo_ctrl_if.sv | 18 +
 rtl/sram_fifo_obuf.sv | 42 ++++
 rtl/sram_fifo_ctrl.sv | 99 +++++++++
 tb/tb_sram_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants for the 128x16 dual-port SRAM and the FIFO controller built around it.
package sram_fifo_ctrl_pkg;
   localparam int SRAM_WIDTH = 16;
   localparam int SRAM_DEPTH = 128;
   localparam int SRAM_AW    = 7;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop valid-ready handshake bundle for the SRAM-backed FIFO.
interface sram_fifo_ctrl_if
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int WIDTH = SRAM_WIDTH
);
   logic             push_valid;
   logic [WIDTH-1:0] push_data;
   logic             push_ready;
   logic             pop_valid;
   logic [WIDTH-1:0] pop_data;
   logic             pop_ready;

   modport master (output push_valid, push_data, pop_ready,
                   input  push_ready, pop_valid, pop_data);
   modport slave  (input  push_valid, push_data, pop_ready,
                   output push_ready, pop_valid, pop_data);
endinterface

// File: rtl/sram_fifo_obuf.sv
// Two-entry output buffer: absorbs SRAM read data so pop_data comes from a register.
module sram_fifo_obuf
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int WIDTH = SRAM_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cap_vld,
   input  logic [WIDTH-1:0] cap_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       occ
);
   logic [WIDTH-1:0] tail_q;

   // pop is only ever asserted with occ != 0, and capture never lands on a full buffer
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         occ  <= 2'd0;
         head <= '0;
      end else begin
         unique case ({cap_vld, pop})
            2'b10: begin
               if (occ == 2'd0) head <= cap_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail_q;
               occ  <= occ - 2'd1;
            end
            2'b11: head <= (occ == 2'd2) ? tail_q : cap_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if ((cap_vld && !pop && occ != 2'd0) || (cap_vld && pop && occ == 2'd2))
         tail_q <= cap_data;
   end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over an external dual-port SRAM: port 0 writes, port 1 reads with 1-cycle latency.
module sram_fifo_ctrl
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int WIDTH = SRAM_WIDTH,
   parameter int DEPTH = SRAM_DEPTH,
   parameter int AW    = SRAM_AW
) (
   input  logic             CLK,
   input  logic             RST,
   sram_fifo_ctrl_if.slave  bus,
   output logic             CE0,
   output logic [AW-1:0]    A0,
   output logic [WIDTH-1:0] D0,
   output logic             WE0,
   output logic [WIDTH-1:0] WEM0,
   output logic             CE1,
   output logic [AW-1:0]    A1,
   output logic [WIDTH-1:0] D1,
   output logic             WE1,
   output logic [WIDTH-1:0] WEM1,
   input  logic [WIDTH-1:0] Q1,
   output logic [AW:0]      count
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]    wptr, rptr, a0_q;
   logic [WIDTH-1:0] d0_q, head;
   logic [AW:0]      sram_cnt;
   logic [1:0]       occ;
   logic [2:0]       rd_load;
   logic             inflight_p1, push_fire, pop_fire, rd_p0;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign bus.push_ready = (count < FULL);
   assign push_fire      = bus.push_valid & bus.push_ready & ~RST;
   assign bus.pop_valid  = (occ != 2'd0);
   assign pop_fire       = bus.pop_valid & bus.pop_ready;
   assign bus.pop_data   = head;

   // buffer slots claimed next cycle: held + arriving - leaving
   assign rd_load = {1'b0, occ} + {2'b00, inflight_p1} - {2'b00, pop_fire};
   assign rd_p0   = (sram_cnt != '0) & (rd_load < 3'd2) & ~RST;

   assign CE0  = push_fire;
   assign WE0  = push_fire;
   assign WEM0 = {WIDTH{push_fire}};
   assign A0   = push_fire ? wptr : a0_q;
   assign D0   = push_fire ? bus.push_data : d0_q;

   assign CE1  = rd_p0;
   assign A1   = rptr;
   assign D1   = '0;
   assign WE1  = 1'b0;
   assign WEM1 = '0;

   // p0: read issue / write accept; p1: SRAM data returns on Q1
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr        <= '0;
         rptr        <= '0;
         a0_q        <= '0;
         d0_q        <= '0;
         sram_cnt    <= '0;
         count       <= '0;
         inflight_p1 <= 1'b0;
      end else begin
         inflight_p1 <= rd_p0;
         if (push_fire) begin
            wptr <= ptr_next(wptr);
            a0_q <= wptr;
            d0_q <= bus.push_data;
         end
         if (rd_p0) rptr <= ptr_next(rptr);
         sram_cnt <= sram_cnt + (AW+1)'(push_fire) - (AW+1)'(rd_p0);
         count    <= count + (AW+1)'(push_fire) - (AW+1)'(pop_fire);
      end
   end

   sram_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
      .CLK      (CLK),
      .RST      (RST),
      .cap_vld  (inflight_p1),
      .cap_data (Q1),
      .pop      (pop_fire),
      .head     (head),
      .occ      (occ)
   );

`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (!RST) assert (!(CE0 && CE1 && (A0 == A1)))
         else $error("SRAM read and write to the same address in one cycle");
   end
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural 1-cycle-latency dual-port SRAM.
`timescale 1ns/1ps
module tb_sram_fifo_ctrl;
   import sram_fifo_ctrl_pkg::*;
   localparam int W  = SRAM_WIDTH;
   localparam int D  = SRAM_DEPTH;
   localparam int AW = SRAM_AW;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   sram_fifo_ctrl_if #(.WIDTH(W)) bus();

   logic          CE0, WE0, CE1, WE1;
   logic [AW-1:0] A0, A1;
   logic [W-1:0]  D0, WEM0, D1, WEM1, Q1;
   logic [AW:0]   count;

   sram_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .bus(bus),
      .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
      .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(Q1),
      .count(count)
   );

   logic [W-1:0] mem [D];
   always @(posedge CLK) begin
      if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
      if (CE1) Q1 <= mem[A1];
   end

   int errs = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   int mdl_cnt = 0;
   logic pf, qf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic sample();
      @(negedge CLK); #1;
   endtask

   // Monitor: accepted pushes feed the queue, every pop is compared against its head
   always @(negedge CLK) begin
      if (!RST) begin
         pf = bus.pop_valid && bus.pop_ready;
         qf = bus.push_valid && (mdl_cnt < D);
         chk("mon_push_ready", 32'(bus.push_ready), 32'(mdl_cnt < D));
         chk("mon_count", 32'(count), mdl_cnt);
         if (pf) begin
            if (exp_q.size() == 0) begin
               checks++; errs++;
               $display("FAIL mon_pop_underflow: got %0h expected no pop", bus.pop_data);
            end else begin
               chk("mon_pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
            end
         end
         if (qf) exp_q.push_back(bus.push_data);
         mdl_cnt = mdl_cnt + int'(qf) - int'(pf);
      end
   end

   task automatic drain(input string nm);
      int n = 0;
      step(); bus.push_valid = 1'b0; bus.pop_ready = 1'b1; sample();
      while ((mdl_cnt != 0 || bus.pop_valid) && n < 400) begin
         step(); sample(); n++;
      end
      if (n >= 400) begin
         checks++; errs++;
         $display("FAIL %s_drain_timeout: got count=%0d expected 0", nm, count);
      end
      chk({nm, "_pop_valid_low"}, 32'(bus.pop_valid), 0);
      chk({nm, "_count_zero"}, 32'(count), 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bus.push_valid = 1'b0; bus.push_data = '0; bus.pop_ready = 1'b0;

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_push_ready", 32'(bus.push_ready), 1);
      chk("rst_pop_valid", 32'(bus.pop_valid), 0);
      chk("rst_pop_data", 32'(bus.pop_data), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ce0", 32'(CE0), 0);
      chk("rst_we0", 32'(WE0), 0);
      chk("rst_a0", 32'(A0), 0);
      chk("rst_d0", 32'(D0), 0);
      chk("rst_ce1", 32'(CE1), 0);
      chk("rst_a1", 32'(A1), 0);
      chk("rst_we1", 32'(WE1), 0);
      chk("rst_wem1", 32'(WEM1), 0);
      chk("rst_d1", 32'(D1), 0);
      step(); RST = 1'b0;
      sample();
      chk("post_rst_push_ready", 32'(bus.push_ready), 1);

      // single word latency
      step(); bus.push_valid = 1'b1; bus.push_data = 16'h1234; bus.pop_ready = 1'b1;
      sample();
      chk("one_ce0", 32'(CE0), 1);
      chk("one_we0", 32'(WE0), 1);
      chk("one_wem0", 32'(WEM0), 32'hFFFF);
      chk("one_a0", 32'(A0), 0);
      chk("one_d0", 32'(D0), 32'h1234);
      step(); bus.push_valid = 1'b0; bus.push_data = 16'h5555;
      sample();
      chk("one_ce0_idle", 32'(CE0), 0);
      chk("one_a0_hold", 32'(A0), 0);
      chk("one_d0_hold", 32'(D0), 32'h1234);
      chk("one_ce1", 32'(CE1), 1);
      chk("one_a1", 32'(A1), 0);
      step(); sample();
      chk("one_pop_valid_t2", 32'(bus.pop_valid), 0);
      step(); sample();
      chk("one_pop_valid_t3", 32'(bus.pop_valid), 1);
      chk("one_pop_data_t3", 32'(bus.pop_data), 32'h1234);
      step(); sample();
      chk("one_pop_valid_after", 32'(bus.pop_valid), 0);

      // fill to full, reject overflow, read-issue throttling on a full buffer
      bus.pop_ready = 1'b0;
      for (int i = 0; i < D; i++) begin
         step(); bus.push_valid = 1'b1; bus.push_data = 16'(i);
      end
      step(); bus.push_data = 16'hDEAD;
      sample();
      chk("full_push_ready", 32'(bus.push_ready), 0);
      chk("full_count", 32'(count), D);
      chk("full_ce0", 32'(CE0), 0);
      chk("full_a0_hold", 32'(A0), 0);
      chk("full_d0_hold", 32'(D0), 32'h007F);
      step(); bus.push_valid = 1'b0;
      sample();
      chk("full_no_read_a", 32'(CE1), 0);
      step(); sample();
      chk("full_no_read_b", 32'(CE1), 0);
      step(); bus.pop_ready = 1'b1;
      sample();
      chk("full_pop_reads", 32'(CE1), 1);
      step(); bus.pop_ready = 1'b0;
      sample();
      chk("full_one_read_per_pop", 32'(CE1), 0);
      drain("full");

      // streaming with pointer wrap
      for (int i = 0; i < 300; i++) begin
         step(); bus.push_valid = 1'b1; bus.push_data = 16'($urandom); bus.pop_ready = 1'b1;
         sample();
         chk("stream_a0", 32'(A0), (1 + i) % D);
         if (i >= 1) begin
            chk("stream_ce1", 32'(CE1), 1);
            chk("stream_a1", 32'(A1), i % D);
         end
         if (i >= 3) chk("stream_pop_valid", 32'(bus.pop_valid), 1);
      end
      drain("stream");

      // reset mid-operation with a read in flight
      bus.pop_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(); bus.push_valid = 1'b1; bus.push_data = 16'(16'h5000 + i);
      end
      step(); bus.push_data = 16'h5032; bus.pop_ready = 1'b1;
      sample();
      chk("mid_read_issued", 32'(CE1), 1);
      step(); bus.push_valid = 1'b0; bus.pop_ready = 1'b0;
      sample();
      chk("mid_count_50", 32'(count), 50);
      RST = 1'b1;
      #1;
      exp_q.delete();
      mdl_cnt = 0;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_pop_valid", 32'(bus.pop_valid), 0);
      chk("mid_rst_pop_data", 32'(bus.pop_data), 0);
      chk("mid_rst_a0", 32'(A0), 0);
      chk("mid_rst_a1", 32'(A1), 0);
      chk("mid_rst_ce1", 32'(CE1), 0);
      chk("mid_rst_push_ready", 32'(bus.push_ready), 1);
      step(); RST = 1'b0;
      sample();
      chk("mid_post_push_ready", 32'(bus.push_ready), 1);
      chk("mid_post_pop_valid", 32'(bus.pop_valid), 0);
      step(); bus.push_valid = 1'b1; bus.push_data = 16'hBEEF; bus.pop_ready = 1'b1;
      lat = 0;
      do begin
         step(); bus.push_valid = 1'b0; lat++; sample();
      end while (!bus.pop_valid && lat < 10);
      chk("mid_beef_latency", lat, 3);
      chk("mid_beef_data", 32'(bus.pop_data), 32'hBEEF);
      drain("mid");

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         step();
         bus.push_valid = 1'($urandom_range(0, 1));
         bus.push_data  = 16'($urandom);
         bus.pop_ready  = 1'($urandom_range(0, 1));
      end
      drain("rand");
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
